// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - instruction memory request/ready bus
interface inst_fetch_unit_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  // Fetch unit side: drives the address and request, receives the word
  modport master (
    output imem_addr,
    output imem_req,
    input  imem_rdata,
    input  imem_ready
  );

  // Memory side: answers a request with data and a ready strobe
  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - PC holder and instruction fetch stage ahead of the decoder
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst_b,
  inst_fetch_unit_if.master         imem,
  output logic [31:0]               inst,
  output logic                      inst_valid,
  output logic [31:0]               pc,
  output logic [31:0]               pc_plus4,
  input  logic                      branch,
  input  logic                      zero,
  input  logic [31:0]               branch_imm,
  input  logic                      jump,
  input  logic                      halted,
  input  logic                      stall,
  output logic                      fetch_halted,
  output logic [31:0]               retired_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] retired_q, retired_d;
  logic [31:0] pc_plus4_w;
  logic [31:0] next_pc;

  // An instruction leaves ISSUE only on a cycle where downstream accepts it
  logic        issue_accept;

  assign pc_plus4_w   = pc_q + 32'd4;
  assign issue_accept = (state_q == S_ISSUE) && !stall;

  // State register; reset abandons any fetch in flight
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: halt wins over jump/branch, stall pins ISSUE, HALT is sticky
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (imem.imem_ready) state_d = S_ISSUE;
      S_ISSUE: if (!stall) state_d = halted ? S_HALT : S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded purely from state and registers, never from inputs
  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc_q;
    inst_valid     = 1'b0;
    fetch_halted   = 1'b0;
    case (state_q)
      S_FETCH: imem.imem_req = 1'b1;
      S_ISSUE: inst_valid    = 1'b1;
      S_HALT:  fetch_halted  = 1'b1;
      default: ;
    endcase
  end

  // Next PC selection: jump over taken branch over sequential
  always_comb begin
    next_pc = pc_plus4_w;
    if (jump) begin
      next_pc = {pc_plus4_w[31:28], inst_q[25:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4_w + (branch_imm << 2);
    end
  end

  // Datapath next-state: capture on ready, advance PC and count on accept
  always_comb begin
    pc_d      = pc_q;
    inst_d    = inst_q;
    retired_d = retired_q;
    if ((state_q == S_FETCH) && imem.imem_ready) begin
      inst_d = imem.imem_rdata;
    end
    if (issue_accept) begin
      retired_d = retired_q + 32'd1;
      if (!halted) begin
        pc_d = next_pc;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pc_q      <= RESET_PC;
      inst_q    <= 32'd0;
      retired_q <= 32'd0;
    end else begin
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      retired_q <= retired_d;
    end
  end

  assign inst          = inst_q;
  assign pc            = pc_q;
  assign pc_plus4      = pc_plus4_w;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed checks of fetch, wait states, branch, jump, stall, halt, reset
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst_b;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch;
  logic        zero;
  logic [31:0] branch_imm;
  logic        jump;
  logic        halted;
  logic        stall;
  logic        fetch_halted;
  logic [31:0] retired_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_ret;

  inst_fetch_unit_if imem_if ();

  inst_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .imem          (imem_if.master),
    .inst          (inst),
    .inst_valid    (inst_valid),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .branch        (branch),
    .zero          (zero),
    .branch_imm    (branch_imm),
    .jump          (jump),
    .halted        (halted),
    .stall         (stall),
    .fetch_halted  (fetch_halted),
    .retired_count (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: fixed words at 0 and 0x3000_0000, address-tagged elsewhere
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h2002_0005;
    if (a == 32'h3000_0000) return 32'h0800_0040;
    return {16'hA5A5, a[15:0]};
  endfunction

  assign imem_if.imem_rdata = mem_word(imem_if.imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From FETCH with ready=1: one edge captures the word and enters ISSUE
  task automatic fetch_issue(input logic [31:0] exp_pc);
    imem_if.imem_ready = 1'b1;
    check("fi_req", {31'd0, imem_if.imem_req}, 32'd1);
    step();
    check("fi_valid", {31'd0, inst_valid}, 32'd1);
    check("fi_pc", pc, exp_pc);
    check("fi_inst", inst, mem_word(exp_pc));
  endtask

  // Accept the instruction in ISSUE with the given decoder outputs
  task automatic retire(input logic j, input logic b, input logic z,
                        input logic [31:0] imm, input logic [31:0] exp_pc);
    jump = j; branch = b; zero = z; branch_imm = imm; halted = 1'b0; stall = 1'b0;
    step();
    exp_ret = exp_ret + 32'd1;
    jump = 1'b0; branch = 1'b0; zero = 1'b0; branch_imm = 32'd0;
    check("rt_addr", imem_if.imem_addr, exp_pc);
    check("rt_req", {31'd0, imem_if.imem_req}, 32'd1);
    check("rt_valid", {31'd0, inst_valid}, 32'd0);
    check("rt_count", retired_count, exp_ret);
  endtask

  initial begin
    rst_b = 1'b0;
    branch = 1'b0; zero = 1'b0; branch_imm = 32'd0; jump = 1'b0;
    halted = 1'b0; stall = 1'b0;
    imem_if.imem_ready = 1'b1;
    exp_ret = 32'd0;

    // Reset state
    #12;
    check("rst_req", {31'd0, imem_if.imem_req}, 32'd0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_halted", {31'd0, fetch_halted}, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_count", retired_count, 32'd0);
    step();
    rst_b = 1'b1;

    // IDLE -> FETCH at address 0, then capture with ready in first FETCH cycle
    step();
    check("f0_req", {31'd0, imem_if.imem_req}, 32'd1);
    check("f0_addr", imem_if.imem_addr, 32'd0);
    step();
    check("f0_inst", inst, 32'h2002_0005);
    check("f0_valid", {31'd0, inst_valid}, 32'd1);
    check("f0_pc4", pc_plus4, 32'd4);
    retire(0, 0, 0, 32'd0, 32'h4);
    fetch_issue(32'h4);
    retire(0, 0, 0, 32'd0, 32'h8);

    // Three wait states at pc=8
    imem_if.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("ws_req", {31'd0, imem_if.imem_req}, 32'd1);
      check("ws_addr", imem_if.imem_addr, 32'h8);
      check("ws_valid", {31'd0, inst_valid}, 32'd0);
      step();
    end
    check("ws_inst_held", inst, 32'hA5A5_0004);
    fetch_issue(32'h8);

    // Taken backward branch at 0x10 to 0x04
    retire(0, 0, 0, 32'd0, 32'hC);
    fetch_issue(32'hC);
    retire(0, 0, 0, 32'd0, 32'h10);
    fetch_issue(32'h10);
    retire(0, 1, 1, 32'hFFFF_FFFC, 32'h4);

    // Same branch at 0x10 not taken (zero=0)
    fetch_issue(32'h4);
    retire(0, 0, 0, 32'd0, 32'h8);
    fetch_issue(32'h8);
    retire(0, 0, 0, 32'd0, 32'hC);
    fetch_issue(32'hC);
    retire(0, 0, 0, 32'd0, 32'h10);
    fetch_issue(32'h10);
    retire(0, 1, 0, 32'hFFFF_FFFC, 32'h14);

    // Long forward branch to 0x3000_0000: 0x18 + 0x0BFF_FFFA*4
    fetch_issue(32'h14);
    retire(0, 1, 1, 32'h0BFF_FFFA, 32'h3000_0000);

    // Jump with branch also high: jump wins
    fetch_issue(32'h3000_0000);
    retire(1, 1, 1, 32'd0, 32'h3000_0100);

    // Two stall cycles in ISSUE, then accept with a negative branch to 0x20
    fetch_issue(32'h3000_0100);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("st_valid", {31'd0, inst_valid}, 32'd1);
      check("st_req", {31'd0, imem_if.imem_req}, 32'd0);
      check("st_count", retired_count, exp_ret);
      check("st_pc", pc, 32'h3000_0100);
    end
    retire(0, 1, 1, 32'hF3FF_FFC7, 32'h20);

    // Halt at 0x20, with jump also high to show halt priority
    fetch_issue(32'h20);
    halted = 1'b1; jump = 1'b1; stall = 1'b0;
    step();
    exp_ret = exp_ret + 32'd1;
    halted = 1'b0; jump = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("h_flag", {31'd0, fetch_halted}, 32'd1);
      check("h_req", {31'd0, imem_if.imem_req}, 32'd0);
      check("h_valid", {31'd0, inst_valid}, 32'd0);
      check("h_pc", pc, 32'h20);
      check("h_count", retired_count, exp_ret);
      step();
    end

    // Asynchronous reset mid-HALT, away from any clock edge
    #2;
    rst_b = 1'b0;
    #1;
    check("ar_pc", pc, 32'd0);
    check("ar_halted", {31'd0, fetch_halted}, 32'd0);
    check("ar_count", retired_count, 32'd0);
    check("ar_inst", inst, 32'd0);
    check("ar_req", {31'd0, imem_if.imem_req}, 32'd0);
    exp_ret = 32'd0;
    imem_if.imem_ready = 1'b0;
    step();
    rst_b = 1'b1;
    step();
    step();
    check("fw_req", {31'd0, imem_if.imem_req}, 32'd1);
    check("fw_addr", imem_if.imem_addr, 32'd0);

    // Reset during a FETCH wait with ready high: nothing captured
    imem_if.imem_ready = 1'b1;
    #2;
    rst_b = 1'b0;
    step();
    check("fr_inst", inst, 32'd0);
    check("fr_valid", {31'd0, inst_valid}, 32'd0);
    check("fr_req", {31'd0, imem_if.imem_req}, 32'd0);
    rst_b = 1'b1;
    step();
    fetch_issue(32'h0);

    // PC wrap: branch to 0xFFFF_FFFC, then sequential advance to 0
    retire(0, 1, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC);
    fetch_issue(32'hFFFF_FFFC);
    check("wr_pc4", pc_plus4, 32'd0);
    retire(0, 0, 0, 32'd0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
